// File: rtl/conv_weight_streamer_pkg.sv
// Shared defaults, word-width helper and FSM state encoding for the conv weight streamer.
package conv_weight_streamer_pkg;

  localparam int unsigned CW_CONV_CHANNEL = 4;
  localparam int unsigned CW_KERNEL_SIZE  = 25;
  localparam int unsigned CW_DATA_WIDTH   = 8;
  localparam int unsigned CW_PASS_W       = 10;

  function automatic int unsigned word_width(input int unsigned dw, input int unsigned ch);
    return dw * ch;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/conv_weight_streamer_skid_fifo.sv
// Two-entry skid FIFO with registered head; push and pop may coincide at any occupancy.
module weight_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_dout  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          if (r_count != 2'd2) r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; a full FIFO shifts tail forward while taking the new word
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_din;
          end else begin
            r_head <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: rtl/conv_weight_streamer.sv
// Sweeps the weight ROM once per pass and streams tagged weight words over valid/ready.
module conv_weight_streamer
  import conv_weight_streamer_pkg::*;
#(
  parameter int unsigned CONV_CHANNEL = CW_CONV_CHANNEL,
  parameter int unsigned KERNEL_SIZE  = CW_KERNEL_SIZE,
  parameter int unsigned DATA_WIDTH   = CW_DATA_WIDTH,
  parameter int unsigned PASS_W       = CW_PASS_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [PASS_W-1:0]                    num_passes,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rom_en,
  output logic [$clog2(KERNEL_SIZE)-1:0]       rom_addr,
  input  logic [DATA_WIDTH*CONV_CHANNEL-1:0]   rom_data,
  output logic                                 w_valid,
  input  logic                                 w_ready,
  output logic [DATA_WIDTH*CONV_CHANNEL-1:0]   w_data,
  output logic [$clog2(KERNEL_SIZE)-1:0]       w_tap,
  output logic                                 w_last,
  output logic                                 w_pass_last
);

  localparam int unsigned TAP_W  = $clog2(KERNEL_SIZE);
  localparam int unsigned WORD_W = word_width(DATA_WIDTH, CONV_CHANNEL);
  localparam int unsigned SB_W   = TAP_W + 2;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_SIZE - 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [TAP_W-1:0]    r_tap;
  logic [PASS_W-1:0]   r_pass;
  logic [PASS_W-1:0]   r_num_passes;
  logic                r_inflight;
  logic [SB_W-1:0]     r_sb;

  logic                w_issue;
  logic                w_tap_wrap;
  logic                w_final_pass;
  logic                w_pop;
  logic [1:0]          w_count;
  logic [2:0]          w_occ;
  logic                w_fifo_valid;
  logic [WORD_W+SB_W-1:0] w_head;

  assign w_tap_wrap   = (r_tap == TAP_LAST);
  assign w_final_pass = (r_pass == r_num_passes - PASS_W'(1));
  assign w_pop        = w_fifo_valid && w_ready;
  // words already queued or in flight from the ROM, minus the one leaving this cycle
  assign w_occ        = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == ST_ISSUE) && (w_occ < 3'd2);

  assign rom_en      = w_issue;
  assign rom_addr    = r_tap;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FINISH);
  assign w_valid     = w_fifo_valid;
  assign w_data      = w_head[WORD_W-1:0];
  assign w_tap       = w_head[WORD_W +: TAP_W];
  assign w_last      = w_head[WORD_W+SB_W-2];
  assign w_pass_last = w_head[WORD_W+SB_W-1];

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_next_state = (num_passes == '0) ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:  if (w_issue && w_tap_wrap && w_final_pass) w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_pop && w_pass_last) w_next_state = ST_FINISH;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tap        <= '0;
      r_pass       <= '0;
      r_num_passes <= '0;
      r_inflight   <= 1'b0;
      r_sb         <= '0;
    end else begin
      r_state    <= w_next_state;
      r_inflight <= w_issue;
      if ((r_state == ST_IDLE) && start) begin
        r_num_passes <= num_passes;
        r_tap        <= '0;
        r_pass       <= '0;
      end else if (w_issue) begin
        r_sb <= {w_tap_wrap && w_final_pass, w_tap_wrap, r_tap};
        if (w_tap_wrap) begin
          r_tap  <= '0;
          r_pass <= r_pass + PASS_W'(1);
        end else begin
          r_tap <= r_tap + TAP_W'(1);
        end
      end
    end
  end

  weight_skid_fifo #(
    .WIDTH(WORD_W + SB_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_din  ({r_sb, rom_data}),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_valid(w_fifo_valid),
    .o_count(w_count)
  );

endmodule

// File: tb/tb_conv_weight_streamer.sv
// Directed bench for conv_weight_streamer with a 1-cycle ROM model and beat scoreboard.
module tb_conv_weight_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  num_passes;
  logic        busy;
  logic        done;
  logic        rom_en;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [4:0]  w_tap;
  logic        w_last;
  logic        w_pass_last;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;

  bit mon_on = 0;
  int np_exp, exp_tap, exp_pass;
  int n_beats, n_rom, n_busy, n_done, n_bubble, n_last, n_plast;
  int first_v, last_beat;
  bit stalled;
  logic [4:0]  held_tap;
  logic [31:0] held_data;

  conv_weight_streamer #(
    .CONV_CHANNEL(4),
    .KERNEL_SIZE (25),
    .DATA_WIDTH  (8),
    .PASS_W      (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_passes (num_passes),
    .busy       (busy),
    .done       (done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_tap      (w_tap),
    .w_last     (w_last),
    .w_pass_last(w_pass_last)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rom_en) rom_data <= {4{3'b000, rom_addr}};

  function automatic logic [31:0] tap_word(input int t);
    logic [7:0] b;
    b = 8'(t);
    return {b, b, b, b};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: beats must arrive in tap order and hold steady while stalled
  always @(negedge clk) if (mon_on) begin
    if (rom_en) n_rom++;
    if (busy)   n_busy++;
    if (done)   n_done++;
    if (w_valid && first_v < 0) first_v = cyc;
    if (stalled) begin
      check_eq("stall_valid", 32'(w_valid), 32'd1);
      check_eq("stall_tap",   32'(w_tap), 32'(held_tap));
      check_eq("stall_data",  w_data, held_data);
    end
    if (w_valid && w_ready) begin
      check_eq("beat_tap",   32'(w_tap), exp_tap);
      check_eq("beat_data",  w_data, tap_word(exp_tap));
      check_eq("beat_last",  32'(w_last), 32'(exp_tap == 24));
      check_eq("beat_plast", 32'(w_pass_last), 32'(exp_tap == 24 && exp_pass == np_exp - 1));
      if (w_last) n_last++;
      if (w_pass_last) n_plast++;
      n_beats++;
      last_beat = cyc;
      if (exp_tap == 24) begin
        exp_tap = 0;
        exp_pass++;
      end else begin
        exp_tap++;
      end
    end else if (n_beats > 0 && n_beats < np_exp * 25 && w_ready && !w_valid) begin
      n_bubble++;
    end
    stalled   = w_valid && !w_ready;
    held_tap  = w_tap;
    held_data = w_data;
  end

  task automatic mon_clear();
    n_beats = 0; n_rom = 0; n_busy = 0; n_done = 0; n_bubble = 0;
    n_last = 0; n_plast = 0; first_v = -1; last_beat = -1;
    exp_tap = 0; exp_pass = 0; stalled = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input logic [9:0] np, output int t0);
    @(posedge clk); #1;
    num_passes = np;
    np_exp     = int'(np);
    start      = 1;
    t0         = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int poke, output int t_done);
    t_done = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        t_done = cyc;
        break;
      end
      @(posedge clk); #1;
      start = (i == poke);
      if (i == poke) num_passes = 10'd5;
      if (rnd) w_ready = 1'($urandom_range(0, 1));
    end
    start = 0;
    if (t_done < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  int t0, td;

  initial begin
    rst_n = 0; start = 0; w_ready = 0; num_passes = '0;
    mon_clear();
    np_exp = 0;
    #12;
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_rom_en", 32'(rom_en), 32'd0);
    check_eq("rst_valid", 32'(w_valid), 32'd0);
    check_eq("rst_data",  w_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    mon_on = 1;

    // S1: one pass, consumer always ready
    step(2); mon_clear(); w_ready = 1;
    do_start(10'd1, t0);
    wait_done(300, 0, -1, td);
    step(3);
    check_eq("s1_first_valid", first_v, t0 + 3);
    check_eq("s1_beats", n_beats, 25);
    check_eq("s1_bubbles", n_bubble, 0);
    check_eq("s1_done_after_last", td, last_beat + 1);
    check_eq("s1_done_abs", td, t0 + 28);
    check_eq("s1_rom_en", n_rom, 25);
    check_eq("s1_done_count", n_done, 1);
    check_eq("s1_last_count", n_last, 1);
    check_eq("s1_busy_after", 32'(busy), 32'd0);

    // S2: three passes back to back
    mon_clear();
    do_start(10'd3, t0);
    wait_done(500, 0, -1, td);
    step(3);
    check_eq("s2_beats", n_beats, 75);
    check_eq("s2_bubbles", n_bubble, 0);
    check_eq("s2_last_count", n_last, 3);
    check_eq("s2_plast_count", n_plast, 1);
    check_eq("s2_done_after_last", td, last_beat + 1);
    check_eq("s2_done_abs", td, t0 + 78);

    // S3: two passes, random backpressure
    mon_clear();
    do_start(10'd2, t0);
    wait_done(2000, 1, -1, td);
    w_ready = 1;
    step(3);
    check_eq("s3_beats", n_beats, 50);
    check_eq("s3_plast_count", n_plast, 1);
    check_eq("s3_done_count", n_done, 1);
    check_eq("s3_rom_en", n_rom, 50);

    // S4: consumer stalled for 10 cycles after start
    mon_clear(); w_ready = 0;
    do_start(10'd1, t0);
    step(9);
    check_eq("s4_rom_en_stalled", n_rom, 2);
    check_eq("s4_valid_stalled", 32'(w_valid), 32'd1);
    check_eq("s4_head_tap", 32'(w_tap), 32'd0);
    check_eq("s4_no_beats", n_beats, 0);
    w_ready = 1;
    wait_done(300, 0, -1, td);
    step(3);
    check_eq("s4_beats", n_beats, 25);
    check_eq("s4_done_count", n_done, 1);

    // S5: zero passes
    mon_clear();
    do_start(10'd0, t0);
    wait_done(20, 0, -1, td);
    step(3);
    check_eq("s5_done_cyc", td, t0 + 1);
    check_eq("s5_busy_cycles", n_busy, 1);
    check_eq("s5_rom_en", n_rom, 0);
    check_eq("s5_beats", n_beats, 0);
    check_eq("s5_first_valid", first_v, -1);

    // S6: reset in the middle of pass 2, then a fresh single pass
    mon_clear();
    do_start(10'd3, t0);
    for (int i = 0; i < 200 && n_beats < 35; i++) step(1);
    check_eq("s6_reached_mid", n_beats, 35);
    mon_on = 0;
    rst_n = 0;
    #1;
    check_eq("s6_rst_busy",   32'(busy), 32'd0);
    check_eq("s6_rst_rom_en", 32'(rom_en), 32'd0);
    check_eq("s6_rst_addr",   32'(rom_addr), 32'd0);
    check_eq("s6_rst_valid",  32'(w_valid), 32'd0);
    check_eq("s6_rst_data",   w_data, 32'd0);
    check_eq("s6_rst_tap",    32'(w_tap), 32'd0);
    check_eq("s6_rst_last",   32'(w_last | w_pass_last), 32'd0);
    step(2);
    rst_n = 1;
    step(2);
    check_eq("s6_idle_after_rst", 32'(busy), 32'd0);
    mon_clear(); mon_on = 1;
    do_start(10'd1, t0);
    wait_done(300, 0, 5, td);
    step(5);
    check_eq("s6_beats", n_beats, 25);
    check_eq("s6_done_count", n_done, 1);
    check_eq("s6_done_abs", td, t0 + 28);
    check_eq("s6_busy_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
